// File: rtl/dgt_raddr_scheduler_if.sv
// Handshake and bus bundle between the flip-filter request generators, the
// read address scheduler and the shared memory read port.
interface dgt_raddr_scheduler_if #(
    parameter int unsigned NUM_REQ     = 256,
    parameter int unsigned PARALLELISM = 4,
    parameter int unsigned NUM_CH      = 2
);
    localparam int unsigned NUM_BLK    = NUM_REQ / PARALLELISM;
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_BLK);
    localparam int unsigned CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         en_i;
    logic                         flush_i;
    logic [NUM_CH-1:0]            req_valid_i;
    logic [NUM_CH-1:0]            req_ready_o;
    logic [NUM_CH*NUM_REQ-1:0]    req_i;
    logic [NUM_CH-1:0]            msb_first_i;
    logic [NUM_CH-1:0]            dense_mode_i;
    logic [ADDR_WIDTH-1:0]        addr_lower_bound_i;
    logic [ADDR_WIDTH-1:0]        addr_upper_bound_i;
    logic                         idx_valid_o;
    logic                         idx_ready_i;
    logic [ADDR_WIDTH-1:0]        idx_o;
    logic [CH_WIDTH-1:0]          ch_o;
    logic [PARALLELISM-1:0]       lane_mask_o;
    logic [NUM_BLK-1:0]           grant_block_one_hot_o;
    logic                         last_o;
    logic                         empty_o;

    modport master (
        output en_i, flush_i, req_valid_i, req_i, msb_first_i, dense_mode_i,
               addr_lower_bound_i, addr_upper_bound_i, idx_ready_i,
        input  req_ready_o, idx_valid_o, idx_o, ch_o, lane_mask_o,
               grant_block_one_hot_o, last_o, empty_o
    );

    modport slave (
        input  en_i, flush_i, req_valid_i, req_i, msb_first_i, dense_mode_i,
               addr_lower_bound_i, addr_upper_bound_i, idx_ready_i,
        output req_ready_o, idx_valid_o, idx_o, ch_o, lane_mask_o,
               grant_block_one_hot_o, last_o, empty_o
    );
endinterface

// File: rtl/dgt_raddr_scheduler.sv
// Multi-channel read address scheduler: compresses per-channel request bitmaps
// into non-empty blocks inside an address window and issues them round-robin.
module dgt_raddr_scheduler #(
    parameter int unsigned NUM_REQ     = 256,
    parameter int unsigned PARALLELISM = 4,
    parameter int unsigned NUM_CH      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dgt_raddr_scheduler_if.slave bus
);
    localparam int unsigned NUM_BLK    = NUM_REQ / PARALLELISM;
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_BLK);
    localparam int unsigned CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_BLK-1:0]    pend_q [NUM_CH];
    logic [NUM_BLK-1:0]    pend_d [NUM_CH];
    logic [NUM_REQ-1:0]    lane_q [NUM_CH];
    logic [NUM_REQ-1:0]    lane_d [NUM_CH];
    logic [NUM_CH-1:0]     order_q, order_d;
    logic [NUM_CH-1:0]     loaded_q, loaded_d;
    logic [CH_WIDTH-1:0]   rr_q, rr_d;
    logic [CH_WIDTH-1:0]   lock_ch_q, lock_ch_d;
    logic                  lock_q, lock_d;

    logic                  sel_any;
    logic                  sel_last;
    logic                  found;
    logic                  hs;
    logic [CH_WIDTH-1:0]   sel_ch;
    logic [CH_WIDTH-1:0]   cand;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic [ADDR_WIDTH-1:0] blk;
    logic [NUM_BLK-1:0]    sel_pend;
    logic [NUM_REQ-1:0]    sel_lanes;
    logic [PARALLELISM-1:0] lane_sel;

    // Channel pick (locked channel wins), then block pick in that channel's scan order.
    always_comb begin : select
        sel_any   = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        found     = 1'b0;
        sel_idx   = '0;
        blk       = '0;
        lane_sel  = '0;
        if (lock_q) begin
            sel_any = 1'b1;
            sel_ch  = lock_ch_q;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cand = CH_WIDTH'((32'(rr_q) + i) % NUM_CH);
                if (!sel_any && loaded_q[cand]) begin
                    sel_any = 1'b1;
                    sel_ch  = cand;
                end
            end
        end
        sel_pend  = pend_q[sel_ch];
        sel_lanes = lane_q[sel_ch];
        for (int unsigned b = 0; b < NUM_BLK; b++) begin
            blk = order_q[sel_ch] ? ADDR_WIDTH'(NUM_BLK - 1 - b) : ADDR_WIDTH'(b);
            if (!found && sel_pend[blk]) begin
                found   = 1'b1;
                sel_idx = blk;
            end
        end
        for (int unsigned b = 0; b < NUM_BLK; b++) begin
            if (ADDR_WIDTH'(b) == sel_idx) lane_sel = sel_lanes[b*PARALLELISM +: PARALLELISM];
        end
        sel_last = sel_any && ((sel_pend & (sel_pend - NUM_BLK'(1))) == '0);
    end

    assign hs = bus.en_i & sel_any & bus.idx_ready_i;

    always_comb begin : next_state
        pend_d    = pend_q;
        lane_d    = lane_q;
        order_d   = order_q;
        loaded_d  = loaded_q;
        rr_d      = rr_q;
        lock_ch_d = lock_ch_q;
        lock_d    = lock_q;
        if (bus.flush_i) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                pend_d[c] = '0;
                lane_d[c] = '0;
            end
            order_d   = '0;
            loaded_d  = '0;
            rr_d      = '0;
            lock_ch_d = '0;
            lock_d    = 1'b0;
        end else if (bus.en_i) begin
            if (hs) begin
                pend_d[sel_ch][sel_idx] = 1'b0;
                if (sel_last) loaded_d[sel_ch] = 1'b0;
                rr_d   = CH_WIDTH'((32'(sel_ch) + 32'd1) % NUM_CH);
                lock_d = 1'b0;
            end else if (sel_any) begin
                lock_d    = 1'b1;
                lock_ch_d = sel_ch;
            end
            // A busy channel cannot be the load target, so loads never collide with the handshake.
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (bus.req_valid_i[c] && !loaded_q[c]) begin
                    for (int unsigned b = 0; b < NUM_BLK; b++) begin
                        pend_d[c][b] = (ADDR_WIDTH'(b) >= bus.addr_lower_bound_i)
                                    && (ADDR_WIDTH'(b) <= bus.addr_upper_bound_i)
                                    && (bus.dense_mode_i[c]
                                        || (|bus.req_i[c*NUM_REQ + b*PARALLELISM +: PARALLELISM]));
                    end
                    lane_d[c]   = bus.req_i[c*NUM_REQ +: NUM_REQ];
                    order_d[c]  = bus.msb_first_i[c];
                    loaded_d[c] = |pend_d[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                pend_q[c] <= '0;
                lane_q[c] <= '0;
            end
            order_q   <= '0;
            loaded_q  <= '0;
            rr_q      <= '0;
            lock_ch_q <= '0;
            lock_q    <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            lane_q    <= lane_d;
            order_q   <= order_d;
            loaded_q  <= loaded_d;
            rr_q      <= rr_d;
            lock_ch_q <= lock_ch_d;
            lock_q    <= lock_d;
        end
    end

    assign bus.req_ready_o           = ~loaded_q;
    assign bus.empty_o               = ~|loaded_q;
    assign bus.idx_valid_o           = bus.en_i & sel_any;
    assign bus.idx_o                 = sel_any ? sel_idx : '0;
    assign bus.ch_o                  = sel_any ? sel_ch : '0;
    assign bus.lane_mask_o           = sel_any ? lane_sel : '0;
    assign bus.last_o                = sel_last;
    assign bus.grant_block_one_hot_o = sel_any ? (NUM_BLK'(1) << sel_idx) : '0;
endmodule

// File: tb/tb_dgt_raddr_scheduler.sv
// Scoreboard bench for dgt_raddr_scheduler with 16 requests, 4 lanes, 2 channels.
module tb_dgt_raddr_scheduler;
    typedef struct packed {
        logic [1:0] idx;
        logic       ch;
        logic [3:0] lane;
        logic       last;
        logic [3:0] grant;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    chk_cnt = 0;
    int    pass_cnt = 0;
    beat_t exp_q[$];

    dgt_raddr_scheduler_if #(.NUM_REQ(16), .PARALLELISM(4), .NUM_CH(2)) bus ();

    dgt_raddr_scheduler #(.NUM_REQ(16), .PARALLELISM(4), .NUM_CH(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Every accepted beat is checked against the oldest expected beat.
    always @(negedge clk) begin
        beat_t got, e;
        if (rst_n && bus.idx_valid_o && bus.idx_ready_i) begin
            got = {bus.idx_o, bus.ch_o, bus.lane_mask_o, bus.last_o, bus.grant_block_one_hot_o};
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat got=%h", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL beat got idx=%0d ch=%0d lane=%b last=%b grant=%b exp idx=%0d ch=%0d lane=%b last=%b grant=%b",
                                        got.idx, got.ch, got.lane, got.last, got.grant,
                                        e.idx, e.ch, e.lane, e.last, e.grant);
                else pass_cnt++;
            end
        end
    end

    function automatic void push(input int idx, input int ch, input logic [3:0] lane, input logic last);
        beat_t b;
        b.idx   = 2'(idx);
        b.ch    = 1'(ch);
        b.lane  = lane;
        b.last  = last;
        b.grant = 4'(1 << idx);
        exp_q.push_back(b);
    endfunction

    task automatic idle_inputs();
        bus.en_i               = 1'b1;
        bus.flush_i            = 1'b0;
        bus.req_valid_i        = 2'b00;
        bus.req_i              = '0;
        bus.msb_first_i        = 2'b00;
        bus.dense_mode_i       = 2'b00;
        bus.addr_lower_bound_i = 2'd0;
        bus.addr_upper_bound_i = 2'd3;
        bus.idx_ready_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        exp_q.delete();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present a load for one cycle; returns at posedge+1 after the load edge.
    task automatic load(input logic [1:0] vld, input logic [15:0] r0, input logic [15:0] r1,
                        input logic [1:0] msb, input logic [1:0] dense, input int lo, input int hi);
        bus.req_valid_i        = vld;
        bus.req_i              = {r1, r0};
        bus.msb_first_i        = msb;
        bus.dense_mode_i       = dense;
        bus.addr_lower_bound_i = 2'(lo);
        bus.addr_upper_bound_i = 2'(hi);
        @(posedge clk);
        #1 bus.req_valid_i = 2'b00;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.empty_o) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        chk_cnt++;
        if (exp_q.size() != 0 || !bus.empty_o)
            $display("FAIL %s_drain left=%0d empty=%b required left=0 empty=1", name, exp_q.size(), bus.empty_o);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({bus.idx_valid_o, bus.last_o, bus.idx_o, bus.ch_o, bus.lane_mask_o, bus.grant_block_one_hot_o,
             bus.empty_o, bus.req_ready_o} !== {1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 4'd0, 1'b1, 2'b11})
            $display("FAIL reset_values valid=%b empty=%b ready=%b required 0/1/11",
                     bus.idx_valid_o, bus.empty_o, bus.req_ready_o);
        else pass_cnt++;
        load(2'b01, 16'h0F01, 16'h0, 2'b00, 2'b00, 0, 3);
        #3 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.idx_valid_o, bus.idx_o, bus.lane_mask_o, bus.empty_o, bus.req_ready_o} !== {1'b0, 2'd0, 4'd0, 1'b1, 2'b11})
            $display("FAIL async_reset valid=%b lane=%b empty=%b ready=%b required 0/0000/1/11",
                     bus.idx_valid_o, bus.lane_mask_o, bus.empty_o, bus.req_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_lsb_order();
        do_reset();
        bus.idx_ready_i = 1'b1;
        bus.req_valid_i = 2'b01;
        bus.req_i       = {16'h0, 16'h0F01};
        @(negedge clk);
        chk_cnt++;
        if (bus.idx_valid_o !== 1'b0) $display("FAIL load_latency valid=%b required 0", bus.idx_valid_o);
        else pass_cnt++;
        push(0, 0, 4'b0001, 1'b0);
        push(2, 0, 4'b1111, 1'b1);
        @(posedge clk);
        #1 bus.req_valid_i = 2'b00;
        wait_drain("lsb", 20);
        chk_cnt++;
        if ({bus.req_ready_o, bus.empty_o} !== {2'b11, 1'b1})
            $display("FAIL lsb_after ready=%b empty=%b required 11/1", bus.req_ready_o, bus.empty_o);
        else pass_cnt++;
    endtask

    task automatic test_msb_order();
        do_reset();
        bus.idx_ready_i = 1'b1;
        push(2, 0, 4'b1111, 1'b0);
        push(0, 0, 4'b0001, 1'b1);
        load(2'b01, 16'h0F01, 16'h0, 2'b01, 2'b00, 0, 3);
        wait_drain("msb", 20);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.idx_ready_i = 1'b1;
        push(0, 0, 4'b0001, 1'b0);
        push(3, 1, 4'b0001, 1'b1);
        push(1, 0, 4'b0001, 1'b1);
        load(2'b11, 16'h0011, 16'h1000, 2'b00, 2'b00, 0, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.idx_valid_o !== 1'b1) $display("FAIL b2b_valid cycle=%0d valid=%b required 1", k, bus.idx_valid_o);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        wait_drain("b2b", 20);
    endtask

    task automatic test_stall();
        do_reset();
        load(2'b11, 16'h0011, 16'h1000, 2'b00, 2'b00, 0, 3);
        for (int k = 0; k < 3; k++) begin
            bus.req_valid_i = (k == 1) ? 2'b10 : 2'b00;
            bus.req_i       = {16'hFFFF, 16'h0011};
            @(negedge clk);
            chk_cnt++;
            if ({bus.idx_valid_o, bus.idx_o, bus.ch_o, bus.lane_mask_o, bus.last_o, bus.req_ready_o}
                !== {1'b1, 2'd0, 1'b0, 4'b0001, 1'b0, 2'b00})
                $display("FAIL stall_hold cycle=%0d valid=%b idx=%0d ch=%0d lane=%b last=%b ready=%b required 1/0/0/0001/0/00",
                         k, bus.idx_valid_o, bus.idx_o, bus.ch_o, bus.lane_mask_o, bus.last_o, bus.req_ready_o);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 2'b00;
        push(0, 0, 4'b0001, 1'b0);
        push(3, 1, 4'b0001, 1'b1);
        push(1, 0, 4'b0001, 1'b1);
        bus.idx_ready_i = 1'b1;
        wait_drain("stall", 20);
    endtask

    task automatic test_dense_window();
        do_reset();
        bus.idx_ready_i = 1'b1;
        push(1, 1, 4'b0000, 1'b0);
        push(2, 1, 4'b0000, 1'b1);
        load(2'b10, 16'h0, 16'h0, 2'b00, 2'b10, 1, 2);
        wait_drain("dense", 20);
        load(2'b10, 16'h0, 16'hFFFF, 2'b00, 2'b00, 3, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bus.idx_valid_o, bus.req_ready_o, bus.empty_o} !== {1'b0, 2'b11, 1'b1})
                $display("FAIL inverted_window cycle=%0d valid=%b ready=%b empty=%b required 0/11/1",
                         k, bus.idx_valid_o, bus.req_ready_o, bus.empty_o);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush_enable();
        do_reset();
        bus.idx_ready_i = 1'b1;
        push(0, 0, 4'b0001, 1'b0);
        load(2'b01, 16'h0F01, 16'h0, 2'b00, 2'b00, 0, 3);
        @(posedge clk);
        #1;
        bus.idx_ready_i = 1'b0;
        bus.flush_i     = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.idx_valid_o, bus.empty_o, bus.req_ready_o, exp_q.size() == 0} !== {1'b0, 1'b1, 2'b11, 1'b1})
            $display("FAIL flush valid=%b empty=%b ready=%b left=%0d required 0/1/11/0",
                     bus.idx_valid_o, bus.empty_o, bus.req_ready_o, exp_q.size());
        else pass_cnt++;
        @(posedge clk);
        #1;
        load(2'b01, 16'h0F01, 16'h0, 2'b00, 2'b00, 0, 3);
        bus.en_i        = 1'b0;
        bus.idx_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bus.idx_valid_o, bus.idx_o, bus.empty_o} !== {1'b0, 2'd0, 1'b0})
                $display("FAIL en_low cycle=%0d valid=%b idx=%0d empty=%b required 0/0/0",
                         k, bus.idx_valid_o, bus.idx_o, bus.empty_o);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        push(0, 0, 4'b0001, 1'b0);
        push(2, 0, 4'b1111, 1'b1);
        bus.en_i = 1'b1;
        wait_drain("en_resume", 20);
    endtask

    initial begin
        test_reset();
        test_lsb_order();
        test_msb_order();
        test_back_to_back();
        test_stall();
        test_dense_window();
        test_flush_enable();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dgt_raddr_scheduler.md
Name: dgt_raddr_scheduler

Overview:
Multi-channel successor of the digital read address manager. It holds up to NUM_CH independent request bitmaps and compresses each into non-empty PARALLELISM-wide blocks inside a runtime address window. It issues block addresses round-robin across channels, with channel ID and per-block lane mask, over a valid/ready handshake. It sits between the flip-filter request generators and the shared weight/spin memory read port.

Parameters:
NUM_REQ, 256, request bits per channel
PARALLELISM, 4, request bits per block (one memory word)
NUM_CH, 2, independent request channels
ADDR_WIDTH, $clog2(NUM_REQ/PARALLELISM), block address width (derived)
CH_WIDTH, (NUM_CH>1)?$clog2(NUM_CH):1, channel ID width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  global enable; low freezes all state
flush_i  in  1  synchronous clear of all channels
req_valid_i  in  NUM_CH  per-channel load strobe
req_ready_o  out  NUM_CH  channel idle, can accept load
req_i  in  NUM_CH*NUM_REQ  request bitmaps; channel c = [c*NUM_REQ +: NUM_REQ]
msb_first_i  in  NUM_CH  per-channel scan order, sampled at load
dense_mode_i  in  NUM_CH  per-channel: issue every block in window regardless of content, sampled at load
addr_lower_bound_i  in  ADDR_WIDTH  first block in window, sampled at load
addr_upper_bound_i  in  ADDR_WIDTH  last block in window, inclusive, sampled at load
idx_valid_o  out  1  output beat valid
idx_ready_i  in  1  consumer ready
idx_o  out  ADDR_WIDTH  block address
ch_o  out  CH_WIDTH  channel of beat
lane_mask_o  out  PARALLELISM  request bits of the issued block
grant_block_one_hot_o  out  NUM_REQ/PARALLELISM  one-hot of idx_o
last_o  out  1  beat is the channel's final block
empty_o  out  1  no channel holds pending blocks

Behaviour:
- Reset and flush values:
  - idx_valid_o, last_o, idx_o, ch_o, lane_mask_o and grant_block_one_hot_o are 0.
  - empty_o is 1 and req_ready_o is all 1.
  - The round-robin pointer is 0.
- Per-channel state: pending-block register (NUM_REQ/PARALLELISM bits), lane store (NUM_REQ bits), order bit and loaded flag.
- req_ready_o[c] = ~loaded[c] and is registered-state only.
- Load happens when en_i & req_valid_i[c] & req_ready_o[c] & ~flush_i.
  - Normal mode: pending[b] = |block b of req_i, AND window mask (lower <= b <= upper).
  - Dense mode: pending = window mask.
  - Lane store captures req_i. loaded[c] is set only if pending is non-zero.
  - A load whose pending set is zero (empty, or lower > upper) is accepted and discarded; the channel stays idle.
- Latency: a beat can appear at the earliest in the cycle after the load.
- Selection:
  - Among loaded channels, pick the first at or after the round-robin pointer.
  - Within that channel, pick the lowest pending block, or the highest if its order bit is set.
  - idx_o is the block index. lane_mask_o is the lane store slice, and may be 0 in dense mode.
- last_o = 1 when the selected channel has exactly one pending bit.
- Stability: once idx_valid_o is high without idx_ready_i, the selected channel is locked in a register. idx_o, ch_o, lane_mask_o and last_o stay constant until handshake or flush, even if other channels load.
- On handshake (idx_valid_o & idx_ready_i & en_i):
  - The issued bit is cleared.
  - The round-robin pointer goes to (ch_o+1) mod NUM_CH.
  - If last_o, loaded[ch_o] clears and req_ready_o[ch_o] rises next cycle.
  - Throughput is one beat per cycle when the consumer is ready.
- Simultaneous events:
  - A last beat and a load request on the same channel: the load is refused, since ready was low.
  - Loads on several channels in one cycle are all accepted.
  - flush_i beats load and handshake.
- en_i low: idx_valid_o is forced 0, no state changes, and the locked selection is retained.
- empty_o = ~|loaded.
- Reset asserted mid-operation: all state returns to reset values asynchronously.

Test Plan:
Use NUM_REQ=16, PARALLELISM=4, NUM_CH=2 and bounds 0..3 unless stated.
1. Load ch0 req=16'h0F01, LSB order, ready=1 -> beats (idx0, ch0, lane 0001, last 0) then (idx2, ch0, lane 1111, last 1); req_ready_o[0] high the next cycle; empty_o=1 afterwards.
2. Same load with msb_first_i[0]=1 -> idx2 then idx0, last on idx0.
3. Load ch0 req=16'h0011 and ch1 req=16'h1000 in the same cycle, ready=1 -> beats in order:
   - ch0 idx0
   - ch1 idx3 with last=1
   - ch0 idx1 with last=1
4. Scenario 3 with ready low for 3 cycles after the first valid beat, and a ch1 reload attempt during the stall -> outputs hold ch0/idx0 unchanged; the ch1 load is refused because ch1 is busy.
5. Dense mode on ch1, req=0, bounds 1..2 -> beats idx1 lane 0000, then idx2 lane 0000 with last=1. Separately, bounds 3..1 in normal mode -> load discarded, ch1 never issues.
6. flush_i after the first beat of scenario 1 -> next cycle idx_valid_o=0, empty_o=1, req_ready_o=2'b11. Then en_i low during a pending beat -> idx_valid_o=0, and the same beat resumes when en_i rises.
